// File: rtl/counter_updown_mod.sv
// counter_updown_mod: modulo up/down counter, wrap or saturate at 0..MAX_VAL.
// Ports: clk, rst (sync, active-high), en, dir (1=up), load, load_val,
// count, wrap (1-cycle pulse), at_max, at_min. Define
// COUNTER_UPDOWN_WRAP_CNT_EN to add wrap_cnt[15:0], a saturating wrap tally.
module counter_updown_mod #(
  parameter int unsigned WIDTH     = 4,
  parameter int unsigned MAX_VAL   = 15,
  parameter int unsigned SATURATE  = 0,
  parameter int unsigned RESET_VAL = 0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic             dir,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] count,
  output logic             wrap,
  output logic             at_max,
`ifdef COUNTER_UPDOWN_WRAP_CNT_EN
  output logic             at_min,
  output logic [15:0]      wrap_cnt
`else
  output logic             at_min
`endif
);

  localparam longint unsigned TOP =
    (64'd1 << WIDTH) - 64'd1;

  if (WIDTH < 1 || WIDTH > 32) begin : g_bad_width
    $error("counter_updown_mod: WIDTH out of range");
  end
  if (MAX_VAL < 1 || longint'(MAX_VAL) > TOP) begin : g_bad_max
    $error("counter_updown_mod: MAX_VAL out of range");
  end
  if (RESET_VAL > MAX_VAL) begin : g_bad_rst
    $error("counter_updown_mod: RESET_VAL above MAX_VAL");
  end

  localparam logic [WIDTH-1:0] MAX_C = WIDTH'(MAX_VAL);
  localparam logic [WIDTH-1:0] RST_C = WIDTH'(RESET_VAL);
  localparam logic [WIDTH-1:0] ONE   = WIDTH'(1);
  localparam logic [WIDTH-1:0] ZERO  = '0;
  localparam bit               SAT   = (SATURATE != 0);

  logic [WIDTH-1:0] nxt;
  logic [WIDTH-1:0] lv_clamp;
  logic             nwrap;
  logic             step_up;
  logic             step_dn;

  assign at_max = (count == MAX_C);
  assign at_min = (count == ZERO);

  assign lv_clamp = (load_val > MAX_C) ? MAX_C : load_val;
  assign step_up  = !load && en && dir;
  assign step_dn  = !load && en && !dir;

  // Limits are tested before stepping, so +1/-1 never
  // leaves 0..MAX_VAL and WIDTH-bit roll-over is never used.
  always_comb begin
    nxt   = count;
    nwrap = 1'b0;
    unique case (1'b1)
      load: nxt = lv_clamp;
      step_up: begin
        if (!at_max) begin
          nxt = count + ONE;
        end else if (!SAT) begin
          nxt   = ZERO;
          nwrap = 1'b1;
        end
      end
      step_dn: begin
        if (!at_min) begin
          nxt = count - ONE;
        end else if (!SAT) begin
          nxt   = MAX_C;
          nwrap = 1'b1;
        end
      end
      default: nxt = count;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= RST_C;
      wrap  <= 1'b0;
    end else begin
      count <= nxt;
      wrap  <= nwrap;
    end
  end

`ifdef COUNTER_UPDOWN_WRAP_CNT_EN
  // Counts on the same edge the wrap pulse is registered;
  // sticks at all-ones, load does not clear it.
  always_ff @(posedge clk) begin
    if (rst) begin
      wrap_cnt <= 16'h0000;
    end else if (nwrap && wrap_cnt != 16'hFFFF) begin
      wrap_cnt <= wrap_cnt + 16'h0001;
    end
  end
`endif

endmodule

// File: tb/tb_counter_updown_mod.sv
// tb_counter_updown_mod: directed + random check of a wrapping and a
// saturating counter_updown_mod (WIDTH=4, MAX_VAL=9) against a model.
module tb_counter_updown_mod;

  localparam int W = 4;
  localparam int M = 9;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic         rst;
  logic         en;
  logic         dir;
  logic         load;
  logic [W-1:0] load_val;

  logic [W-1:0] count_w;
  logic         wrap_w;
  logic         at_max_w;
  logic         at_min_w;
  logic [W-1:0] count_s;
  logic         wrap_s;
  logic         at_max_s;
  logic         at_min_s;
`ifdef COUNTER_UPDOWN_WRAP_CNT_EN
  logic [15:0]  wrap_cnt_w;
  logic [15:0]  wrap_cnt_s;
`endif

  counter_updown_mod #(
    .WIDTH(W), .MAX_VAL(M), .SATURATE(0), .RESET_VAL(0)
  ) dut_w (
    .clk(clk), .rst(rst), .en(en), .dir(dir),
    .load(load), .load_val(load_val),
    .count(count_w), .wrap(wrap_w),
    .at_max(at_max_w),
`ifdef COUNTER_UPDOWN_WRAP_CNT_EN
    .at_min(at_min_w),
    .wrap_cnt(wrap_cnt_w)
`else
    .at_min(at_min_w)
`endif
  );

  counter_updown_mod #(
    .WIDTH(W), .MAX_VAL(M), .SATURATE(1), .RESET_VAL(0)
  ) dut_s (
    .clk(clk), .rst(rst), .en(en), .dir(dir),
    .load(load), .load_val(load_val),
    .count(count_s), .wrap(wrap_s),
    .at_max(at_max_s),
`ifdef COUNTER_UPDOWN_WRAP_CNT_EN
    .at_min(at_min_s),
    .wrap_cnt(wrap_cnt_s)
`else
    .at_min(at_min_s)
`endif
  );

  int vectors     = 0;
  int miscompares = 0;

  // reference state: wrapping and saturating copies
  int mc_w = 0, mc_s = 0;
  bit mw_w = 0, mw_s = 0;
  int mn_w = 0, mn_s = 0;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %0d expected %0d",
             tag, obs, exp);
    end
  endtask

  function automatic void model(
    input bit r, input bit e, input bit d,
    input bit l, input int lv, input bit sat,
    inout int c, inout bit w, inout int n);
    int t;
    w = 0;
    if (r) begin
      c = 0;
      n = 0;
    end else if (l) begin
      c = (lv > M) ? M : lv;
    end else if (e) begin
      t = d ? c + 1 : c - 1;
      if (t > M || t < 0) begin
        if (!sat) begin
          c = (t + M + 1) % (M + 1);
          w = 1;
        end
      end else begin
        c = t;
      end
    end
    if (w && n < 65535) n++;
  endfunction

  task automatic check_all();
    chk("w.count",  32'(count_w),  mc_w);
    chk("w.wrap",   32'(wrap_w),   32'(mw_w));
    chk("w.at_max", 32'(at_max_w), 32'(mc_w == M));
    chk("w.at_min", 32'(at_min_w), 32'(mc_w == 0));
    chk("s.count",  32'(count_s),  mc_s);
    chk("s.wrap",   32'(wrap_s),   32'(mw_s));
    chk("s.at_max", 32'(at_max_s), 32'(mc_s == M));
    chk("s.at_min", 32'(at_min_s), 32'(mc_s == 0));
`ifdef COUNTER_UPDOWN_WRAP_CNT_EN
    chk("w.wrap_cnt", 32'(wrap_cnt_w), mn_w);
    chk("s.wrap_cnt", 32'(wrap_cnt_s), mn_s);
`endif
  endtask

  task automatic cycle(input bit r, input bit e,
                       input bit d, input bit l,
                       input int lv);
    rst      = r;
    en       = e;
    dir      = d;
    load     = l;
    load_val = W'(lv);
    @(posedge clk);
    #1;
    model(r, e, d, l, lv, 0, mc_w, mw_w, mn_w);
    model(r, e, d, l, lv, 1, mc_s, mw_s, mn_s);
    check_all();
  endtask

  initial begin
    rst = 1; en = 0; dir = 0; load = 0; load_val = '0;

    // reset beats load and en
    cycle(1, 1, 1, 1, 5);
    cycle(1, 1, 1, 1, 5);
    chk("t1.count", 32'(count_w), 0);
    chk("t1.at_min", 32'(at_min_w), 1);

    // up through the 9 -> 0 wrap
    for (int i = 0; i < 12; i++) begin
      cycle(0, 1, 1, 0, 0);
      if (i == 9) chk("t2.wrap", 32'(wrap_w), 1);
    end
    chk("t2.count", 32'(count_w), 2);

    // down through the 0 -> 9 wrap
    for (int i = 0; i < 4; i++) cycle(0, 1, 0, 0, 0);
    chk("t3.count", 32'(count_w), 8);

    // saturating copy holds at both limits
    cycle(0, 0, 0, 1, 8);
    for (int i = 0; i < 3; i++) cycle(0, 1, 1, 0, 0);
    chk("t4.sat_hi", 32'(count_s), 9);
    chk("t4.sat_wrap", 32'(wrap_s), 0);
    cycle(0, 0, 0, 1, 1);
    cycle(0, 1, 0, 0, 0);
    cycle(0, 1, 0, 0, 0);
    chk("t4.sat_lo", 32'(count_s), 0);

    // load clamps and beats en
    cycle(0, 1, 1, 1, 13);
    chk("t5.clamp", 32'(count_w), 9);
    cycle(0, 1, 1, 1, 4);
    chk("t5.load", 32'(count_w), 4);

    // wrap tally: three full up cycles, load, reset
    cycle(1, 0, 0, 0, 0);
    for (int i = 0; i < 30; i++) cycle(0, 1, 1, 0, 0);
`ifdef COUNTER_UPDOWN_WRAP_CNT_EN
    chk("t6.cnt3", 32'(wrap_cnt_w), 3);
`endif
    cycle(0, 0, 0, 1, 2);
`ifdef COUNTER_UPDOWN_WRAP_CNT_EN
    chk("t6.load_keep", 32'(wrap_cnt_w), 3);
`endif
    for (int i = 0; i < 5; i++) cycle(0, 1, 1, 0, 0);
    cycle(1, 1, 1, 0, 0);
`ifdef COUNTER_UPDOWN_WRAP_CNT_EN
    chk("t6.rst", 32'(wrap_cnt_w), 0);
`endif

    // random traffic
    for (int i = 0; i < 500; i++) begin
      cycle($urandom_range(0, 59) == 0,
            $urandom_range(0, 3) != 0,
            1'($urandom_range(0, 1)),
            $urandom_range(0, 11) == 0,
            int'($urandom_range(0, 15)));
    end

    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
